// File: rtl/pow_pkg.sv
// Shared definitions for the proof-of-work nonce search engine: FNV-1a constants,
// FSM state encoding and the single-byte hash step used by RTL and bench alike.
package pow_pkg;

  localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME  = 32'h01000193;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HASH  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] fnv1a_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'd0, b};
    return x * FNV_PRIME;
  endfunction

endpackage

// File: rtl/pow_nonce_search_if.sv
// Host-side bundle of the nonce search engine: search request inputs and result outputs.
interface pow_nonce_search_if #(
  parameter int NONCE_W     = 32,
  parameter int BLOCK_BYTES = 12,
  parameter int TARGET_W    = 16
);
  logic                     start;
  logic                     abort;
  logic [BLOCK_BYTES*8-1:0] block;
  logic [TARGET_W-1:0]      target;
  logic [NONCE_W-1:0]       nonce_start;
  logic                     busy;
  logic                     finish;
  logic                     found;
  logic                     aborted;
  logic [NONCE_W-1:0]       nonce;
  logic [31:0]              hash;
  logic [NONCE_W:0]         attempts;

  modport master (
    output start, abort, block, target, nonce_start,
    input  busy, finish, found, aborted, nonce, hash, attempts
  );

  modport slave (
    input  start, abort, block, target, nonce_start,
    output busy, finish, found, aborted, nonce, hash, attempts
  );
endinterface

// File: rtl/pow_hash_lane.sv
// One FNV-1a-32 accumulator lane: loads the offset basis on init, folds one byte per step.
module pow_hash_lane
  import pow_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        step,
  input  logic [7:0]  din,
  output logic [31:0] h
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
    end else if (init) begin
      h <= FNV_OFFSET;
    end else if (step) begin
      h <= fnv1a_step(h, din);
    end
  end

endmodule

// File: rtl/pow_nonce_search.sv
// Proof-of-work nonce search: LANES parallel FNV-1a lanes hash {block, base+i} one byte
// per cycle, then a single CHECK cycle picks the lowest qualifying lane or advances base.
module pow_nonce_search #(
  parameter int LANES       = 4,
  parameter int NONCE_W     = 32,
  parameter int BLOCK_BYTES = 12,
  parameter int TARGET_W    = 16
) (
  input logic               clk,
  input logic               reset,
  pow_nonce_search_if.slave bus
);
  import pow_pkg::*;

  localparam int MSG_BYTES = BLOCK_BYTES + NONCE_W / 8;
  localparam int CNT_W     = $clog2(MSG_BYTES + 1);
  localparam int ATT_W     = NONCE_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MSG_BYTES - 1);
  localparam logic [CNT_W-1:0]   CNT_BLK   = CNT_W'(BLOCK_BYTES);
  localparam logic [NONCE_W-1:0] LANE_MASK = NONCE_W'(LANES - 1);
  localparam logic [NONCE_W-1:0] BASE_STEP = NONCE_W'(LANES);
  localparam logic [ATT_W-1:0]   ATT_MAX   = ATT_W'(1) << NONCE_W;
  localparam logic [ATT_W-1:0]   ATT_STEP  = ATT_W'(LANES);

  state_t state, state_nx;

  logic [CNT_W-1:0]         cnt;
  logic [BLOCK_BYTES*8-1:0] blk_q;
  logic [TARGET_W-1:0]      tgt_q;
  logic [NONCE_W-1:0]       base;

  logic                     go;
  logic                     busy;
  logic                     lane_init;
  logic                     lane_step;
  logic [31:0]              lane_h [LANES];

  logic                     hit;
  logic [NONCE_W-1:0]       hit_nonce;
  logic [31:0]              hit_h;
  logic [ATT_W-1:0]         att_nx;
  logic                     exhausted;

  logic                     finish_q;
  logic                     found_q;
  logic                     aborted_q;
  logic [NONCE_W-1:0]       nonce_q;
  logic [31:0]              hash_q;
  logic [ATT_W-1:0]         att_q;

  logic                     in_block;
  logic [CNT_W-1:0]         nb_idx;
  logic [CNT_W+2:0]         blk_bit;
  logic [CNT_W+2:0]         nb_bit;
  logic [7:0]               blk_byte;

  assign go       = bus.start && !bus.abort;
  assign in_block = cnt < CNT_BLK;
  assign nb_idx   = cnt - CNT_BLK;
  assign blk_bit  = {cnt, 3'b000};
  assign nb_bit   = {nb_idx, 3'b000};
  assign blk_byte = blk_q[blk_bit +: 8];

  // Header bytes are common to every lane; only the trailing nonce bytes differ.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [NONCE_W-1:0] ln;
    logic [7:0]         din;

    assign ln  = base + NONCE_W'(g);
    assign din = in_block ? blk_byte : ln[nb_bit +: 8];

    pow_hash_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .init  (lane_init),
      .step  (lane_step),
      .din   (din),
      .h     (lane_h[g])
    );
  end

  // Scan downwards so the lowest-index qualifying lane is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_nonce = base;
    hit_h     = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_h[i][31 -: TARGET_W] < tgt_q) begin
        hit       = 1'b1;
        hit_nonce = base + NONCE_W'(i);
        hit_h     = lane_h[i];
      end
    end
  end

  assign att_nx    = (att_q > ATT_MAX - ATT_STEP) ? ATT_MAX : att_q + ATT_STEP;
  assign exhausted = (att_nx == ATT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = HASH;
      HASH:    if (bus.abort) state_nx = DONE;
               else if (cnt == CNT_LAST) state_nx = CHECK;
      CHECK:   if (bus.abort || hit || exhausted) state_nx = DONE;
               else state_nx = HASH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lane_init = 1'b0;
    lane_step = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:  lane_init = go;
      HASH:  begin
        lane_step = 1'b1;
        busy      = 1'b1;
      end
      CHECK: begin
        busy      = 1'b1;
        lane_init = !bus.abort && !hit && !exhausted;
      end
      default: ;
    endcase
  end

  // Search context and results; abort wins over a same-cycle CHECK outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      blk_q     <= '0;
      tgt_q     <= '0;
      base      <= '0;
      finish_q  <= 1'b0;
      found_q   <= 1'b0;
      aborted_q <= 1'b0;
      nonce_q   <= '0;
      hash_q    <= '0;
      att_q     <= '0;
    end else begin
      finish_q <= (state == DONE);
      case (state)
        IDLE: if (go) begin
          blk_q     <= bus.block;
          tgt_q     <= bus.target;
          base      <= bus.nonce_start & ~LANE_MASK;
          cnt       <= '0;
          found_q   <= 1'b0;
          aborted_q <= 1'b0;
          att_q     <= '0;
        end
        HASH: if (bus.abort) begin
          aborted_q <= 1'b1;
          found_q   <= 1'b0;
          nonce_q   <= base;
          hash_q    <= '0;
        end else begin
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        CHECK: if (bus.abort) begin
          aborted_q <= 1'b1;
          found_q   <= 1'b0;
          nonce_q   <= base;
          hash_q    <= '0;
        end else begin
          att_q <= att_nx;
          if (hit) begin
            found_q <= 1'b1;
            nonce_q <= hit_nonce;
            hash_q  <= hit_h;
          end else if (exhausted) begin
            found_q <= 1'b0;
            nonce_q <= base;
            hash_q  <= '0;
          end else begin
            base <= base + BASE_STEP;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.finish   = finish_q;
  assign bus.found    = found_q;
  assign bus.aborted  = aborted_q;
  assign bus.nonce    = nonce_q;
  assign bus.hash     = hash_q;
  assign bus.attempts = att_q;

endmodule

// File: tb/tb_pow_nonce_search.sv
// Bench for pow_nonce_search: a 32-bit and an 8-bit nonce instance checked against a
// sequential first-hit search model built on the shared FNV-1a step.
module tb_pow_nonce_search;
  import pow_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  pow_nonce_search_if #(.NONCE_W(32), .BLOCK_BYTES(12), .TARGET_W(16)) b32 ();
  pow_nonce_search_if #(.NONCE_W(8),  .BLOCK_BYTES(12), .TARGET_W(16)) b8 ();

  pow_nonce_search #(.LANES(4), .NONCE_W(32), .BLOCK_BYTES(12), .TARGET_W(16)) dut32 (
    .clk(clk), .reset(reset), .bus(b32)
  );
  pow_nonce_search #(.LANES(4), .NONCE_W(8), .BLOCK_BYTES(12), .TARGET_W(16)) dut8 (
    .clk(clk), .reset(reset), .bus(b8)
  );

  function automatic logic [31:0] ref_hash(input logic [95:0] blk, input logic [31:0] n, input int nw);
    logic [31:0] h;
    h = FNV_OFFSET;
    for (int b = 0; b < 12; b++) h = fnv1a_step(h, blk[8*b +: 8]);
    for (int b = 0; b < nw / 8; b++) h = fnv1a_step(h, n[8*b +: 8]);
    return h;
  endfunction

  // Walk nonces in order from the aligned start; four lanes means rounds of four nonces.
  task automatic model(input logic [95:0] blk, input logic [15:0] tgt, input logic [31:0] ns,
                       input int nw, output logic ef, output logic [31:0] en,
                       output logic [31:0] eh, output logic [32:0] ea, output int ecyc);
    longint unsigned space, mask, first, n;
    int k, kmax, rounds;
    logic [31:0] h;
    space = 64'd1 << nw;
    mask  = space - 1;
    first = longint'(ns) & mask & ~64'd3;
    kmax  = (space < 64'd4096) ? int'(space) : 4096;
    ef = 1'b0; en = '0; eh = '0; k = 0;
    while (k < kmax && !ef) begin
      n = (first + longint'(k)) & mask;
      h = ref_hash(blk, n[31:0], nw);
      if (h[31:16] < tgt) begin
        ef = 1'b1; en = n[31:0]; eh = h;
      end else begin
        k++;
      end
    end
    if (ef) rounds = k / 4 + 1;
    else begin
      rounds = kmax / 4;
      n = (first + space - 4) & mask;
      en = n[31:0];
    end
    ea   = 33'(rounds * 4);
    ecyc = rounds * (12 + nw / 8 + 1) + 1;
  endtask

  task automatic run(input int sel, input logic [95:0] blk, input logic [15:0] tgt,
                     input logic [31:0] ns, input int abort_at, input int limit,
                     output int cyc, output logic f, output logic ab, output logic [31:0] nn,
                     output logic [31:0] hh, output logic [32:0] att);
    @(negedge clk);
    if (sel == 32) begin
      b32.block = blk; b32.target = tgt; b32.nonce_start = ns; b32.start = 1'b1;
    end else begin
      b8.block = blk; b8.target = tgt; b8.nonce_start = ns[7:0]; b8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    b32.start = 1'b0; b8.start = 1'b0;
    b32.block = {$urandom, $urandom, $urandom}; b32.target = 16'($urandom);
    b32.nonce_start = $urandom;
    b8.block = {$urandom, $urandom, $urandom}; b8.target = 16'($urandom);
    b8.nonce_start = 8'($urandom);
    cyc = 0;
    while (1) begin
      b32.abort = (sel == 32 && cyc == abort_at - 1);
      b8.abort  = (sel == 8 && cyc == abort_at - 1);
      @(posedge clk);
      cyc++;
      #1;
      if (sel == 32 ? b32.finish : b8.finish) break;
      if (cyc >= limit) break;
    end
    b32.abort = 1'b0; b8.abort = 1'b0;
    if (sel == 32) begin
      f = b32.found; ab = b32.aborted; nn = b32.nonce; hh = b32.hash; att = b32.attempts;
    end else begin
      f = b8.found; ab = b8.aborted; nn = {24'd0, b8.nonce}; hh = b8.hash;
      att = {24'd0, b8.attempts};
    end
  endtask

  task automatic test_reset();
    nvec++; if (b32.busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got %0b want 0", b32.busy); end
    nvec++; if (b32.finish !== 1'b0) begin nmis++; $display("FAIL reset_finish got %0b want 0", b32.finish); end
    nvec++; if (b32.found !== 1'b0) begin nmis++; $display("FAIL reset_found got %0b want 0", b32.found); end
    nvec++; if (b32.aborted !== 1'b0) begin nmis++; $display("FAIL reset_aborted got %0b want 0", b32.aborted); end
    nvec++; if (b32.nonce !== 32'd0) begin nmis++; $display("FAIL reset_nonce got %h want 0", b32.nonce); end
    nvec++; if (b32.hash !== 32'd0) begin nmis++; $display("FAIL reset_hash got %h want 0", b32.hash); end
    nvec++; if (b32.attempts !== 33'd0) begin nmis++; $display("FAIL reset_attempts got %0d want 0", b32.attempts); end
    nvec++; if (b8.attempts !== 9'd0) begin nmis++; $display("FAIL reset_attempts8 got %0d want 0", b8.attempts); end
  endtask

  task automatic test_first_round(input string tag);
    logic [95:0] blk; logic ef, f, ab; logic [31:0] en, eh, nn, hh; logic [32:0] ea, att;
    int ecyc, cyc;
    blk = {$urandom, $urandom, $urandom};
    model(blk, 16'hFFFF, 32'd0, 32, ef, en, eh, ea, ecyc);
    run(32, blk, 16'hFFFF, 32'd0, 0, 3000, cyc, f, ab, nn, hh, att);
    nvec++; if (cyc !== ecyc) begin nmis++; $display("FAIL %s_cycles got %0d want %0d", tag, cyc, ecyc); end
    nvec++; if (f !== ef) begin nmis++; $display("FAIL %s_found got %0b want %0b", tag, f, ef); end
    nvec++; if (nn !== en) begin nmis++; $display("FAIL %s_nonce got %h want %h", tag, nn, en); end
    nvec++; if (hh !== eh) begin nmis++; $display("FAIL %s_hash got %h want %h", tag, hh, eh); end
    nvec++; if (att !== ea) begin nmis++; $display("FAIL %s_attempts got %0d want %0d", tag, att, ea); end
    nvec++; if (ab !== 1'b0) begin nmis++; $display("FAIL %s_aborted got %0b want 0", tag, ab); end
    @(posedge clk); #1;
    nvec++; if (b32.finish !== 1'b0) begin nmis++; $display("FAIL %s_finish_pulse got %0b want 0", tag, b32.finish); end
    nvec++; if (b32.found !== ef) begin nmis++; $display("FAIL %s_found_hold got %0b want %0b", tag, b32.found, ef); end
    nvec++; if (b32.busy !== 1'b0) begin nmis++; $display("FAIL %s_busy_after got %0b want 0", tag, b32.busy); end
  endtask

  task automatic test_exhaust();
    logic [95:0] blk; logic [31:0] ns; logic f, ab; logic [31:0] nn, hh; logic [32:0] att;
    int cyc;
    blk = {$urandom, $urandom, $urandom};
    ns  = 32'($urandom_range(0, 255));
    run(8, blk, 16'h0000, ns, 0, 2000, cyc, f, ab, nn, hh, att);
    nvec++; if (cyc !== 897) begin nmis++; $display("FAIL exhaust_cycles got %0d want 897", cyc); end
    nvec++; if (f !== 1'b0) begin nmis++; $display("FAIL exhaust_found got %0b want 0", f); end
    nvec++; if (att !== 33'd256) begin nmis++; $display("FAIL exhaust_attempts got %0d want 256", att); end
    nvec++; if (nn !== {24'd0, 8'((ns & 32'hFC) + 32'd252)}) begin
      nmis++; $display("FAIL exhaust_nonce got %h want %h", nn, 8'((ns & 32'hFC) + 32'd252));
    end
    nvec++; if (hh !== 32'd0) begin nmis++; $display("FAIL exhaust_hash got %h want 0", hh); end
  endtask

  task automatic test_hit37();
    logic [95:0] blk; logic [31:0] h37, h, en, eh, nn, hh; logic okb, ef, f, ab;
    logic [32:0] ea, att; int ecyc, cyc;
    okb = 1'b0; h37 = '0; blk = '0;
    for (int t = 0; t < 4000 && !okb; t++) begin
      blk = {$urandom, $urandom, $urandom};
      h37 = ref_hash(blk, 32'd37, 32);
      okb = 1'b1;
      for (int n = 0; n < 37 && okb; n++) begin
        h = ref_hash(blk, 32'(n), 32);
        if (h[31:16] <= h37[31:16]) okb = 1'b0;
      end
    end
    nvec++; if (okb !== 1'b1) begin nmis++; $display("FAIL hit37_setup got %0b want 1", okb); end
    model(blk, h37[31:16] + 16'd1, 32'd0, 32, ef, en, eh, ea, ecyc);
    run(32, blk, h37[31:16] + 16'd1, 32'd0, 0, 3000, cyc, f, ab, nn, hh, att);
    nvec++; if (cyc !== 171) begin nmis++; $display("FAIL hit37_cycles got %0d want 171", cyc); end
    nvec++; if (f !== 1'b1) begin nmis++; $display("FAIL hit37_found got %0b want 1", f); end
    nvec++; if (nn !== 32'd37) begin nmis++; $display("FAIL hit37_nonce got %0d want 37", nn); end
    nvec++; if (hh !== h37) begin nmis++; $display("FAIL hit37_hash got %h want %h", hh, h37); end
    nvec++; if (att !== 33'd40) begin nmis++; $display("FAIL hit37_attempts got %0d want 40", att); end
  endtask

  task automatic test_wrap();
    logic [95:0] blk; logic [31:0] h3, h, nn, hh; logic okb, f, ab; logic [32:0] att; int cyc;
    okb = 1'b0; h3 = '0; blk = '0;
    for (int t = 0; t < 2000 && !okb; t++) begin
      blk = {$urandom, $urandom, $urandom};
      h3  = ref_hash(blk, 32'd3, 8);
      okb = 1'b1;
      for (int n = 248; n < 259 && okb; n++) begin
        h = ref_hash(blk, 32'(n & 255), 8);
        if (h[31:16] <= h3[31:16]) okb = 1'b0;
      end
    end
    nvec++; if (okb !== 1'b1) begin nmis++; $display("FAIL wrap_setup got %0b want 1", okb); end
    run(8, blk, h3[31:16] + 16'd1, 32'hF8, 0, 500, cyc, f, ab, nn, hh, att);
    nvec++; if (cyc !== 43) begin nmis++; $display("FAIL wrap_cycles got %0d want 43", cyc); end
    nvec++; if (f !== 1'b1) begin nmis++; $display("FAIL wrap_found got %0b want 1", f); end
    nvec++; if (nn !== 32'd3) begin nmis++; $display("FAIL wrap_nonce got %0d want 3", nn); end
    nvec++; if (hh !== h3) begin nmis++; $display("FAIL wrap_hash got %h want %h", hh, h3); end
    nvec++; if (att !== 33'd12) begin nmis++; $display("FAIL wrap_attempts got %0d want 12", att); end
  endtask

  task automatic test_random();
    logic [95:0] blk; logic [15:0] tgt; logic [31:0] ns, en, eh, nn, hh; logic ef, f, ab;
    logic [32:0] ea, att; int ecyc, cyc, sel;
    for (int it = 0; it < 6; it++) begin
      sel = (it % 2 == 0) ? 32 : 8;
      blk = {$urandom, $urandom, $urandom};
      ns  = $urandom;
      tgt = (sel == 32) ? 16'($urandom_range(16'h0800, 16'hFFFF)) : 16'($urandom);
      model(blk, tgt, ns, sel, ef, en, eh, ea, ecyc);
      run(sel, blk, tgt, ns, 0, ecyc + 50, cyc, f, ab, nn, hh, att);
      nvec++; if (cyc !== ecyc) begin nmis++; $display("FAIL rand%0d_cycles got %0d want %0d", it, cyc, ecyc); end
      nvec++; if (f !== ef) begin nmis++; $display("FAIL rand%0d_found got %0b want %0b", it, f, ef); end
      nvec++; if (nn !== en) begin nmis++; $display("FAIL rand%0d_nonce got %h want %h", it, nn, en); end
      nvec++; if (hh !== eh) begin nmis++; $display("FAIL rand%0d_hash got %h want %h", it, hh, eh); end
      nvec++; if (att !== ea) begin nmis++; $display("FAIL rand%0d_attempts got %0d want %0d", it, att, ea); end
    end
  endtask

  task automatic test_abort();
    logic f, ab; logic [31:0] nn, hh; logic [32:0] att; int cyc;
    run(32, {$urandom, $urandom, $urandom}, 16'h0000, $urandom, 5, 200, cyc, f, ab, nn, hh, att);
    nvec++; if (cyc !== 6) begin nmis++; $display("FAIL abort_cycles got %0d want 6", cyc); end
    nvec++; if (ab !== 1'b1) begin nmis++; $display("FAIL abort_aborted got %0b want 1", ab); end
    nvec++; if (f !== 1'b0) begin nmis++; $display("FAIL abort_found got %0b want 0", f); end
    nvec++; if (hh !== 32'd0) begin nmis++; $display("FAIL abort_hash got %h want 0", hh); end
    nvec++; if (att !== 33'd0) begin nmis++; $display("FAIL abort_attempts got %0d want 0", att); end
    @(negedge clk);
    b32.start = 1'b1; b32.abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      nvec++; if (b32.busy !== 1'b0) begin nmis++; $display("FAIL start_abort_busy%0d got %0b want 0", i, b32.busy); end
    end
    @(negedge clk);
    b32.start = 1'b0; b32.abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b32.block = {$urandom, $urandom, $urandom}; b32.target = 16'h0000;
    b32.nonce_start = 32'd0; b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    nvec++; if (b32.busy !== 1'b1) begin nmis++; $display("FAIL midreset_busy_before got %0b want 1", b32.busy); end
    #2 reset = 1'b0;
    #1;
    nvec++; if (b32.busy !== 1'b0) begin nmis++; $display("FAIL midreset_busy got %0b want 0", b32.busy); end
    nvec++; if (b32.finish !== 1'b0) begin nmis++; $display("FAIL midreset_finish got %0b want 0", b32.finish); end
    nvec++; if (b32.found !== 1'b0) begin nmis++; $display("FAIL midreset_found got %0b want 0", b32.found); end
    nvec++; if (b32.aborted !== 1'b0) begin nmis++; $display("FAIL midreset_aborted got %0b want 0", b32.aborted); end
    nvec++; if (b32.nonce !== 32'd0) begin nmis++; $display("FAIL midreset_nonce got %h want 0", b32.nonce); end
    nvec++; if (b32.hash !== 32'd0) begin nmis++; $display("FAIL midreset_hash got %h want 0", b32.hash); end
    nvec++; if (b32.attempts !== 33'd0) begin nmis++; $display("FAIL midreset_attempts got %0d want 0", b32.attempts); end
    @(negedge clk);
    reset = 1'b1;
    test_first_round("after_reset");
  endtask

  initial begin
    b32.start = 1'b0; b32.abort = 1'b0; b32.block = '0; b32.target = '0; b32.nonce_start = '0;
    b8.start  = 1'b0; b8.abort  = 1'b0; b8.block  = '0; b8.target  = '0; b8.nonce_start  = '0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_first_round("first_round");
    test_exhaust();
    test_hit37();
    test_wrap();
    test_random();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
